result_drain_4x4: RTL
=====================

Name: result_drain_4x4

Overview:
- Consumer end of the dual 4x4 multiply-add array's result interface.
- Latches both 4x4 result matrices (result1, result2) on a capture strobe, then serialises them element by element over a valid/ready stream towards the output buffer or memory writer.
- Sits directly after the adder stage. Frees the array for its next multiply while the previous results drain.

Parameters:
- width, 8, operand width of the array; result elements are 2*width bits signed.
- SHIFT, 4, right-shift applied when RESULT_REQUANT_EN is defined (ignored otherwise).

Ports:
- clk  in  1  single clock; all state on rising edge.
- _reset  in  1  asynchronous, active-high reset. Asserting it clears all state immediately.
- capture  in  1  one-cycle strobe: results valid (done & AddFlag path complete).
- abort  in  1  synchronous; drops any drain in progress.
- res1_flat  in  32*width  matrix 1. Element i = row*4+col at [i*2*width +: 2*width], signed.
- res2_flat  in  32*width  matrix 2, same packing.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  OUT_W  signed element. OUT_W = 2*width, or width with RESULT_REQUANT_EN.
- out_sel  out  1  0 = matrix 1, 1 = matrix 2.
- out_idx  out  4  element index (row*4+col).
- out_last  out  1  high on beat 31 (matrix 2, idx 15).
- busy  out  1  high in DRAIN.
- overrun  out  1  one-cycle pulse when a capture is dropped.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, out_idx=0, out_last=0, busy=0, overrun=0. State = IDLE, beat counter = 0, capture registers = 0.
- States:
  - IDLE: capture=1 latches res1_flat and res2_flat into a 32-entry register file, clears counter, enters DRAIN.
  - DRAIN: out_valid=1 every cycle.
- Latency: capture sampled at edge N; out_valid=1 with beat 0 from cycle N+1.
- Beat order:
  - Counter c is 5 bits, 0..31. out_sel=c[4], out_idx=c[3:0].
  - Matrix 1 row-major, then matrix 2 row-major.
  - out_data = stored element c.
- Handshake:
  - A beat transfers when out_valid & out_ready; counter increments on transfer.
  - While out_ready=0, out_data, out_sel, out_idx and out_last are held stable. out_valid never drops without a transfer (except on abort or reset).
- Last beat: the transfer at c=31 returns to IDLE, and out_valid=0 on the next cycle.
- Capture during DRAIN:
  - Ignored, registers unchanged, overrun=1 for that cycle.
  - Exception: if capture coincides with the transfer of beat 31, it is accepted. New data is latched, the counter resets to 0, the block stays in DRAIN and out_valid stays 1 with no bubble.
- abort:
  - Abort=1 forces IDLE next cycle with out_valid=0.
  - Abort has priority over transfer.
  - Abort has priority over capture in the same cycle: the capture is lost and no overrun is raised.
- Reset mid-drain: immediate return to reset values; the partial drain is lost.
- Arithmetic: no modification of values without the optional feature; sign is preserved.

Optional Feature:
- Macro: RESULT_REQUANT_EN.
- Defined:
  - OUT_W = width.
  - out_data = saturate(element >>> SHIFT) to [-2^(width-1), 2^(width-1)-1].
  - Shift is arithmetic; it truncates toward minus infinity.
  - Requantisation is applied combinationally on the read path. It adds no latency and leaves the handshake unchanged.
- Undefined: OUT_W = 2*width, raw element passed through; SHIFT unused.

Decomposition:
- Shared package (matrix-array constants):
  - N_DIM = 4, N_ELEM = 16, N_BEATS = 32.
  - State encoding localparams IDLE/DRAIN.
  - The element-slice index function used by the systolic/adder blocks.
- One natural sub-module, requant_sat: a combinational shift-and-saturate, parameterised by width and SHIFT. It is instantiated only under RESULT_REQUANT_EN.

Test Plan:
- Basic drain: res1[i]=i, res2[i]=100+i, capture, out_ready=1 → 32 consecutive beats starting the cycle after capture. Values 0..15 then 100..115; out_sel flips at beat 16; out_last only on beat 31 (value 115); busy falls after.
- Backpressure: same data, out_ready toggled 1,0,0,1 repeatedly → data, idx and sel are stable while stalled; the sequence is identical to the basic drain; no beat is lost or duplicated.
- Overrun and back-to-back:
  - Capture at beat 5 with different data → overrun pulses once and the original data completes.
  - Capture exactly on the beat-31 transfer → new data beat 0 on the next cycle, with out_valid continuously 1.
- Abort and reset: abort at beat 10 → out_valid=0 next cycle, busy=0. Assert _reset asynchronously at beat 20 → all outputs are 0 immediately.
- Negative values: res1[0]=-300 (16'hFED4) → out_data=-300 unmodified.
- RESULT_REQUANT_EN, width=8, SHIFT=4:
  - 1000 → 62.
  - 5000 → 127 (saturated).
  - -300 → -19.
  - -5000 → -128.

Source files
------------

// File: rtl/result_drain_4x4_pkg.sv
// Shared matrix-array constants, drain state encoding and the element-slice helper
// used by the 4x4 multiply-add array blocks.
package result_drain_4x4_pkg;

    localparam int N_DIM   = 4;
    localparam int N_ELEM  = N_DIM * N_DIM;
    localparam int N_BEATS = 2 * N_ELEM;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    // LSB position of element idx (row*4+col) in a flat matrix bus of elem_w-bit elements
    function automatic int elem_lsb(input int idx, input int elem_w);
        return idx * elem_w;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: arithmetic right shift by SHIFT, then saturate the
// 2*width-bit signed element into a signed width-bit result.
module requant_sat #(
    parameter int width = 8,
    parameter int SHIFT = 4
) (
    input  logic signed [2*width-1:0] din,
    output logic signed [width-1:0]   dout
);

    localparam logic signed [2*width-1:0] MAX_V = {{(width+1){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [2*width-1:0] MIN_V = {{(width+1){1'b1}}, {(width-1){1'b0}}};

    logic signed [2*width-1:0] shifted;

    // >>> on a signed operand floors toward minus infinity
    assign shifted = din >>> SHIFT;

    always_comb begin
        dout = shifted[width-1:0];
        if (shifted > MAX_V) begin
            dout = MAX_V[width-1:0];
        end else if (shifted < MIN_V) begin
            dout = MIN_V[width-1:0];
        end
    end

endmodule

// File: rtl/result_drain_4x4.sv
// Latches both 4x4 result matrices on capture and streams them out as 32 valid/ready beats.
// Optional requantised output path is enabled by defining RESULT_REQUANT_EN.
//
// state | meaning
// IDLE  | waiting for capture, out_valid low
// DRAIN | presenting beat cnt, out_valid high
module result_drain_4x4
    import result_drain_4x4_pkg::*;
#(
    parameter int width = 8,
    parameter int SHIFT = 4
) (
    input  logic                      clk,
    input  logic                      _reset,
    input  logic                      capture,
    input  logic                      abort,
    input  logic [32*width-1:0]       res1_flat,
    input  logic [32*width-1:0]       res2_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef RESULT_REQUANT_EN
    output logic signed [width-1:0]   out_data,
`else
    output logic signed [2*width-1:0] out_data,
`endif
    output logic                      out_sel,
    output logic [3:0]                out_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overrun
);

    localparam int EW = 2 * width;

    logic [0:0]           state;
    logic [4:0]           cnt;
    logic signed [EW-1:0] elem_q [N_BEATS];
    logic signed [EW-1:0] cur_elem;
    logic                 xfer;
    logic                 last_beat;
    logic                 load;

    assign busy      = (state == DRAIN);
    assign out_valid = busy;
    assign xfer      = out_valid & out_ready;
    assign last_beat = (cnt == 5'd31);
    assign out_sel   = cnt[4];
    assign out_idx   = cnt[3:0];
    assign out_last  = busy & last_beat;

    // A capture is taken when idle, or when it lands exactly on the final transfer
    assign load    = capture & ~abort & (~busy | (xfer & last_beat));
    assign overrun = capture & ~abort & busy & ~(xfer & last_beat);

    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) begin
            state <= IDLE;
            cnt   <= '0;
            for (int i = 0; i < N_BEATS; i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            if (load) begin
                for (int i = 0; i < N_ELEM; i++) begin
                    elem_q[i]          <= res1_flat[elem_lsb(i, EW) +: EW];
                    elem_q[i + N_ELEM] <= res2_flat[elem_lsb(i, EW) +: EW];
                end
            end
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (load) begin
                state <= DRAIN;
                cnt   <= '0;
            end else if (xfer) begin
                if (last_beat) begin
                    state <= IDLE;
                end
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign cur_elem = elem_q[cnt];

`ifdef RESULT_REQUANT_EN
    requant_sat #(
        .width(width),
        .SHIFT(SHIFT)
    ) u_requant_sat (
        .din (cur_elem),
        .dout(out_data)
    );
`else
    logic [31:0] unused_shift;

    assign unused_shift = SHIFT;
    assign out_data     = cur_elem;
`endif

endmodule
